// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage types and constants
package fetch_pkg;

  localparam int PC_BITS = 8;
  localparam logic [PC_BITS-1:0] RESET_PC = 8'h00;
  localparam int INSN_BYTES = 4;

  // Opcodes shared with the jump-target unit
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_B    = 7'b1100011;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - RV32 instruction fetch: pc, single-outstanding imem request, one-entry output buffer
module pc_fetch
  import fetch_pkg::*;
#(
  parameter int PC_BITS = fetch_pkg::PC_BITS,
  parameter logic [PC_BITS-1:0] RESET_PC = PC_BITS'(fetch_pkg::RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [PC_BITS-1:0] redirect_pc,
  input  logic               stall,
  output logic               imem_req,
  output logic [PC_BITS-1:0] imem_addr,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  output logic               if_valid,
  output logic [31:0]        if_instr,
  output logic [PC_BITS-1:0] if_pc,
  output logic [PC_BITS-1:0] if_link,
  output logic               fetch_fault
);

  fetch_state_e       state, state_nxt;
  logic [PC_BITS-1:0] pc, pc_nxt, pc_plus4;
  logic               kill, kill_nxt;
  logic               fault_nxt;
  logic               capture;
  logic               misaligned;
  logic               active;

  assign pc_plus4   = pc + PC_BITS'(INSN_BYTES);
  assign misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign active     = (state == REQ) | (state == WAIT) | (state == HOLD);

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign if_valid  = (state == HOLD);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    kill_nxt  = kill;
    fault_nxt = fetch_fault;
    capture   = 1'b0;

    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        // The request is already on the bus, so its response must be dropped
        state_nxt = WAIT;
        if (redirect_valid) begin
          pc_nxt   = redirect_pc;
          kill_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_nxt = redirect_pc;
          if (imem_rvalid) begin
            kill_nxt  = 1'b0;
            state_nxt = REQ;
          end else begin
            kill_nxt = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill) begin
            kill_nxt  = 1'b0;
            state_nxt = REQ;
          end else begin
            capture   = 1'b1;
            pc_nxt    = pc_plus4;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          state_nxt = REQ;
        end else if (!stall) begin
          state_nxt = REQ;
        end
      end
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase

    // A misaligned target outranks everything else and freezes the stage
    if (active && misaligned) begin
      fault_nxt = 1'b1;
      state_nxt = HALT;
      pc_nxt    = pc;
      kill_nxt  = 1'b0;
      capture   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      fetch_fault <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_link     <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      kill        <= kill_nxt;
      fetch_fault <= fault_nxt;
      if (capture) begin
        if_instr <= imem_rdata;
        if_pc    <= pc;
        if_link  <= pc_plus4;
      end
    end
  end

endmodule
